alu_sequencer: RTL and testbench

- Multi-cycle control unit that fetches 9-bit instructions from an external instruction ROM, reads a 4x8 internal register file, and drives the shared 8-bit ALU (op, A, B, branch address).
- Writes ALU results back to the register file and sequences the program counter, including ALU-signalled branches.
- Sits between the instruction memory and the ALU; the host preloads registers, pulses start, and waits for done or timeout.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_regfile.sv | 32 +++
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and
// instruction field positions.
package alu_pkg;

  localparam int INSTR_W = 9;

  localparam logic [2:0] OP_HALT   = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_AND    = 3'b011;
  localparam logic [2:0] OP_NOT    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_EQ     = 3'b110;
  localparam logic [2:0] OP_BRANCH = 3'b111;

  // Instruction field positions
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 4;
  localparam int RS_MSB = 3;
  localparam int RS_LSB = 2;
  localparam int RT_MSB = 1;
  localparam int RT_LSB = 0;
  localparam int BA_MSB = 5;
  localparam int BA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WB      = 3'd4,
    ST_DONE    = 3'd5,
    ST_TIMEOUT = 3'd6
  } state_t;

  // True for the ops that write a result back to rd
  function automatic logic op_writes(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-memory and ALU bus shared between the sequencer (master)
// and the ROM/ALU side (slave).
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 6
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [PC_W-1:0]    alu_addr;
  logic [2:0]         alu_op;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_co;
  logic               alu_eq;
  logic               alu_branch;

  modport master (
    output imem_addr, alu_a, alu_b, alu_addr, alu_op,
    input  imem_data, alu_result, alu_co, alu_eq, alu_branch
  );

  modport slave (
    input  imem_addr, alu_a, alu_b, alu_addr, alu_op,
    output imem_data, alu_result, alu_co, alu_eq, alu_branch
  );
endinterface

// File: rtl/alu_regfile.sv
// 4-entry register file: one write port, two operand read ports and a
// debug read port, all reads combinational.
module alu_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [1:0]        raddr_dbg,
  output logic [DATA_W-1:0] rdata_dbg
);
  logic [DATA_W-1:0] regs [4];

  // Register storage with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs[raddr_a];
  assign rdata_b   = regs[raddr_b];
  assign rdata_dbg = regs[raddr_dbg];
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit: fetches instructions, reads operands, drives
// the shared ALU, writes results back and sequences the program counter.
//
// state   | meaning
// IDLE    | waiting for start after reset
// FETCH   | present pc on imem_addr
// DECODE  | instruction word valid; HALT ends the run, else load ALU inputs
// EXEC    | ALU operating on the driven op/operands
// WB      | ALU result valid; write back, advance pc, count step
// DONE    | program reached HALT
// TIMEOUT | instruction budget exhausted
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PC_W      = 6,
  parameter int MAX_STEPS = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              host_we,
  input  logic [1:0]        host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [1:0]        host_raddr,
  output logic [DATA_W-1:0] host_rdata,
  alu_sequencer_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              carry_q
);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [STEP_W-1:0] steps;
  logic [2:0]        op_q;
  logic [1:0]        rd_q;

  logic              host_ok;
  logic              wb_write;
  logic              rf_we;
  logic [1:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [STEP_W-1:0] steps_inc;
  logic [PC_W-1:0]   pc_next;

  // Write-port arbitration and next pc / step values
  always_comb begin
    host_ok   = (state == ST_IDLE) || (state == ST_DONE);
    wb_write  = (state == ST_WB) && op_writes(op_q);
    rf_we     = wb_write || (host_ok && host_we);
    rf_waddr  = wb_write ? rd_q : host_waddr;
    rf_wdata  = wb_write ? bus.alu_result : host_wdata;
    steps_inc = steps + STEP_W'(1);
    pc_next   = bus.alu_branch ? bus.alu_addr : pc + PC_W'(1);
  end

  // Operand reads are addressed straight from the instruction word in DECODE
  alu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr_a   (bus.imem_data[RS_MSB:RS_LSB]),
    .rdata_a   (rdata_a),
    .raddr_b   (bus.imem_data[RT_MSB:RT_LSB]),
    .rdata_b   (rdata_b),
    .raddr_dbg (host_raddr),
    .rdata_dbg (host_rdata)
  );

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc            <= '0;
      steps         <= '0;
      op_q          <= OP_HALT;
      rd_q          <= '0;
      bus.imem_addr <= '0;
      bus.alu_op    <= OP_HALT;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_addr  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      carry_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start) begin
            pc            <= '0;
            steps         <= '0;
            bus.imem_addr <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          bus.imem_addr <= pc;
          state         <= ST_DECODE;
        end
        ST_DECODE: begin
          op_q <= bus.imem_data[OP_MSB:OP_LSB];
          rd_q <= bus.imem_data[RD_MSB:RD_LSB];
          if (bus.imem_data[OP_MSB:OP_LSB] == OP_HALT) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            bus.alu_op   <= bus.imem_data[OP_MSB:OP_LSB];
            bus.alu_a    <= rdata_a;
            bus.alu_b    <= rdata_b;
            bus.alu_addr <= bus.imem_data[BA_MSB:BA_LSB];
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_WB;
        end
        ST_WB: begin
          if (wb_write) carry_q <= bus.alu_co;
          bus.alu_op    <= OP_HALT;
          pc            <= pc_next;
          bus.imem_addr <= pc_next;
          steps         <= steps_inc;
          if (steps_inc == STEP_W'(MAX_STEPS)) begin
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= ST_TIMEOUT;
          end else begin
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a registered instruction ROM and a simple
// registered ALU model on the slave side of the bus.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       host_we = 1'b0;
  logic [1:0] host_waddr = '0;
  logic [7:0] host_wdata = '0;
  logic [1:0] host_raddr = '0;
  logic [7:0] host_rdata;
  logic       busy, done, timeout, carry_q;

  alu_sequencer_if #(.DATA_W(8), .PC_W(6)) bus ();

  alu_sequencer #(.DATA_W(8), .PC_W(6), .MAX_STEPS(255)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .carry_q    (carry_q)
  );

  always #5 clk = ~clk;

  logic [8:0] rom [64];
  logic       eq_flag;

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.alu_result <= '0;
      bus.alu_co     <= 1'b0;
      bus.alu_eq     <= 1'b0;
      bus.alu_branch <= 1'b0;
      eq_flag        <= 1'b0;
    end else begin
      bus.alu_result <= '0;
      bus.alu_co     <= 1'b0;
      bus.alu_eq     <= 1'b0;
      bus.alu_branch <= 1'b0;
      case (bus.alu_op)
        3'b001: {bus.alu_co, bus.alu_result} <= {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        3'b010: {bus.alu_co, bus.alu_result} <= {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        3'b011: bus.alu_result <= bus.alu_a & bus.alu_b;
        3'b100: bus.alu_result <= ~bus.alu_a;
        3'b101: bus.alu_result <= bus.alu_a | bus.alu_b;
        3'b110: begin
          bus.alu_eq <= (bus.alu_a == bus.alu_b);
          eq_flag    <= (bus.alu_a == bus.alu_b);
        end
        3'b111: bus.alu_branch <= eq_flag;
        default: ;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] ri(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic logic [8:0] br(input logic [5:0] a);
    return {3'b111, a};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 9'd0;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    host_we = 1'b1;
    host_waddr = a;
    host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    host_raddr = a;
    #1;
    d = host_rdata;
  endtask

  // Pulse start (host_we may be pre-set by the caller for the same cycle),
  // then wait for done/timeout within a cycle budget.
  task automatic run(input int limit, input bit wr_busy, output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    host_we = 1'b0;
    cyc = 0;
    if (wr_busy) begin
      check("busy_during_run", busy, 1);
      host_we = 1'b1;
      host_waddr = 2'd2;
      host_wdata = 8'd99;
      @(posedge clk); #1;
      host_we = 1'b0;
      cyc = 1;
    end
    while (!done && !timeout && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("run_ended_in_budget", done | timeout, 1);
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [1:0] rd;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] pre_rd;
    logic [7:0] exp_rd;
    logic       chk_c;
    logic       exp_c;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         cyc;
    logic [7:0] d;

    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    logic [7:0] d;

    vecs[0] = '{"add_18_3",     OP_ADD, 2'd0, 8'd18,  8'd3,   8'h00, 8'd21,  1'b1, 1'b0};
    vecs[1] = '{"add_255_255",  OP_ADD, 2'd3, 8'd255, 8'd255, 8'h00, 8'd254, 1'b1, 1'b1};
    vecs[2] = '{"sub_5_3",      OP_SUB, 2'd3, 8'd5,   8'd3,   8'h00, 8'd2,   1'b1, 1'b0};
    vecs[3] = '{"sub_3_5",      OP_SUB, 2'd0, 8'd3,   8'd5,   8'h00, 8'd254, 1'b1, 1'b1};
    vecs[4] = '{"and",          OP_AND, 2'd3, 8'hF0,  8'h3C,  8'h00, 8'h30,  1'b1, 1'b0};
    vecs[5] = '{"not",          OP_NOT, 2'd0, 8'h0F,  8'hAA,  8'h00, 8'hF0,  1'b1, 1'b0};
    vecs[6] = '{"or",           OP_OR,  2'd3, 8'hF0,  8'h0F,  8'h00, 8'hFF,  1'b1, 1'b0};
    vecs[7] = '{"eq_no_write",  OP_EQ,  2'd3, 8'd9,   8'd9,   8'h55, 8'h55,  1'b0, 1'b0};

    clear_rom();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_carry", carry_q, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), d);
      check($sformatf("rst_reg%0d", r), d, 0);
    end

    // Single-instruction programs followed by HALT
    for (int i = 0; i < 8; i++) begin
      clear_rom();
      rom[0] = ri(vecs[i].op, vecs[i].rd, 2'd1, 2'd2);
      host_write(2'd1, vecs[i].a);
      host_write(2'd2, vecs[i].b);
      host_write(vecs[i].rd, vecs[i].pre_rd);
      run(20, 1'b0, cyc);
      check({vecs[i].name, "_done"}, done, 1);
      check({vecs[i].name, "_busy"}, busy, 0);
      check({vecs[i].name, "_timeout"}, timeout, 0);
      read_reg(vecs[i].rd, d);
      check({vecs[i].name, "_rd"}, d, vecs[i].exp_rd);
      if (vecs[i].chk_c) check({vecs[i].name, "_carry"}, carry_q, vecs[i].exp_c);
      if (i == 0) check("add_latency_le8", cyc <= 8, 1);
    end

    // EQ + BRANCH taken, then not taken
    clear_rom();
    rom[0] = ri(OP_EQ, 2'd0, 2'd1, 2'd2);
    rom[1] = br(6'd10);
    host_write(2'd0, 8'h11);
    host_write(2'd1, 8'd7);
    host_write(2'd2, 8'd7);
    run(30, 1'b0, cyc);
    check("br_taken_done", done, 1);
    check("br_taken_pc", bus.imem_addr, 10);
    read_reg(2'd0, d);
    check("br_taken_r0", d, 8'h11);
    read_reg(2'd2, d);
    check("br_taken_r2", d, 7);
    host_write(2'd2, 8'd5);
    run(30, 1'b0, cyc);
    check("br_fall_done", done, 1);
    check("br_fall_pc", bus.imem_addr, 2);
    read_reg(2'd0, d);
    check("br_fall_r0", d, 8'h11);

    // Infinite loop hits the step budget after 255 instructions
    clear_rom();
    rom[0] = ri(OP_EQ, 2'd0, 2'd1, 2'd1);
    rom[1] = br(6'd0);
    run(1100, 1'b0, cyc);
    check("to_timeout", timeout, 1);
    check("to_busy", busy, 0);
    check("to_done", done, 0);
    check("to_cycles", cyc, 255 * 4);
    read_reg(2'd0, d);
    check("to_r0", d, 8'h11);

    // Restart from TIMEOUT
    clear_rom();
    run(20, 1'b0, cyc);
    check("restart_done", done, 1);
    check("restart_timeout_clr", timeout, 0);

    // Host write while busy is ignored, then honoured in DONE
    clear_rom();
    rom[0] = ri(OP_ADD, 2'd0, 2'd1, 2'd2);
    host_write(2'd1, 8'd10);
    host_write(2'd2, 8'd3);
    run(20, 1'b1, cyc);
    read_reg(2'd2, d);
    check("busy_we_r2", d, 3);
    read_reg(2'd0, d);
    check("busy_we_r0", d, 13);
    host_write(2'd2, 8'd99);
    read_reg(2'd2, d);
    check("idle_we_r2", d, 99);

    // Host write and start in the same cycle
    host_we = 1'b1;
    host_waddr = 2'd2;
    host_wdata = 8'd40;
    host_write(2'd1, 8'd2);
    host_we = 1'b1;
    host_waddr = 2'd2;
    host_wdata = 8'd40;
    run(20, 1'b0, cyc);
    read_reg(2'd0, d);
    check("we_start_r0", d, 42);

    // Reset during EXEC of an ADD
    host_write(2'd1, 8'd1);
    host_write(2'd2, 8'd2);
    host_write(2'd0, 8'd77);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (bus.alu_op == 3'd0 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("exec_reached", bus.alu_op, OP_ADD);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_alu_op", bus.alu_op, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_imem_addr", bus.imem_addr, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    read_reg(2'd0, d);
    check("mid_rst_r0", d, 0);
    read_reg(2'd1, d);
    check("mid_rst_r1", d, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
